aes_byte_packer: RTL and testbench

- Serial-to-parallel byte packer for the AES datapath. It is the inverse of the column byte selector.
- Accepts one byte per cycle on a valid/ready stream and assembles four consecutive bytes into a 32-bit column word.
- The first byte goes to bits [31:24] and the fourth to [7:0], the same order the selector uses with sel 0..3.
- Emits words on a valid/ready stream and flags the last word of each 128-bit block. It sits between the byte-wide key/plaintext loader and the word-wide state/key registers.

---
 rtl/aes_byte_packer_pkg.sv | 26 ++
 rtl/aes_byte_packer_if.sv | 23 ++
 rtl/aes_word_out_reg.sv | 38 +++
 rtl/aes_byte_packer.sv | 61 ++++++
 tb/tb_aes_byte_packer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_byte_packer_pkg.sv
// Shared AES datapath widths and the byte-slot ordering common to the packer and the column selector.
package aes_byte_packer_pkg;
    localparam int AES_BYTE_W          = 8;
    localparam int AES_WORD_W          = 32;
    localparam int AES_BYTES_PER_WORD  = 4;
    localparam int AES_WORDS_PER_BLOCK = 4;
    localparam int AES_SLOT_W          = $clog2(AES_BYTES_PER_WORD);
    localparam int AES_WIDX_W          = 4;

    typedef logic [AES_BYTE_W-1:0] aes_byte_t;
    typedef logic [AES_WORD_W-1:0] aes_word_t;
    typedef logic [AES_SLOT_W-1:0] aes_slot_t;
    typedef logic [AES_WIDX_W-1:0] aes_widx_t;

    // Slot 0 is the most significant byte, matching selector sel 0..3.
    function automatic int slot_hi(input aes_slot_t idx);
        return AES_WORD_W - 1 - AES_BYTE_W * int'(idx);
    endfunction

    function automatic aes_word_t place_byte(input aes_word_t w, input aes_slot_t idx,
                                             input aes_byte_t b);
        int sh;
        sh = slot_hi(idx) - (AES_BYTE_W - 1);
        return (w & ~(aes_word_t'({AES_BYTE_W{1'b1}}) << sh)) | (aes_word_t'(b) << sh);
    endfunction
endpackage

// File: rtl/aes_byte_packer_if.sv
// Byte-in / word-out stream bundle of the packer; slave is the packer side.
interface aes_byte_packer_if;
    import aes_byte_packer_pkg::*;

    aes_byte_t byte_in;
    logic      byte_valid;
    logic      byte_ready;
    aes_slot_t byte_idx;
    aes_word_t word_out;
    logic      word_valid;
    logic      word_ready;
    logic      word_last;

    modport master (
        output byte_in, byte_valid, word_ready,
        input  byte_ready, byte_idx, word_out, word_valid, word_last
    );

    modport slave (
        input  byte_in, byte_valid, word_ready,
        output byte_ready, byte_idx, word_out, word_valid, word_last
    );
endinterface

// File: rtl/aes_word_out_reg.sv
// Single-entry registered output stage: loads a finished word, drops valid once it is consumed.
module aes_word_out_reg
    import aes_byte_packer_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_load,
    input  aes_word_t i_word,
    input  logic      i_last,
    input  logic      i_ready,
    output aes_word_t o_word,
    output logic      o_valid,
    output logic      o_last
);
    aes_word_t r_word;
    logic      r_valid;
    logic      r_last;

    // A load in the same cycle as a consume replaces the word with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_last  = r_last;
endmodule

// File: rtl/aes_byte_packer.sv
// Serial-to-parallel packer: four accepted bytes form one column word, last word of a block is flagged.
module aes_byte_packer
    import aes_byte_packer_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = AES_WORDS_PER_BLOCK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    aes_byte_packer_if.slave  bus
);
    localparam aes_widx_t LAST_WIDX = aes_widx_t'(WORDS_PER_BLOCK - 1);
    localparam aes_slot_t LAST_SLOT = aes_slot_t'(AES_BYTES_PER_WORD - 1);

    aes_slot_t r_byte_idx;
    aes_widx_t r_word_idx;
    aes_word_t r_asm;

    logic      w_byte_ready;
    logic      w_byte_fire;
    logic      w_word_load;
    logic      w_word_last;
    aes_word_t w_word;

    // Only the closing byte waits on the output register; earlier slots fill during a stall.
    assign w_byte_ready = rst_n && !abort &&
                          !(r_byte_idx == LAST_SLOT && bus.word_valid && !bus.word_ready);
    assign w_byte_fire  = bus.byte_valid && w_byte_ready;
    assign w_word_load  = w_byte_fire && (r_byte_idx == LAST_SLOT);
    assign w_word_last  = (r_word_idx == LAST_WIDX);
    assign w_word       = place_byte(r_asm, LAST_SLOT, bus.byte_in);

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
        end else if (w_byte_fire) begin
            r_asm      <= place_byte(r_asm, r_byte_idx, bus.byte_in);
            r_byte_idx <= r_byte_idx + 1'b1;
            if (w_word_load) begin
                r_word_idx <= w_word_last ? '0 : r_word_idx + 1'b1;
            end
        end
    end

    aes_word_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_word_load),
        .i_word  (w_word),
        .i_last  (w_word_last),
        .i_ready (bus.word_ready),
        .o_word  (bus.word_out),
        .o_valid (bus.word_valid),
        .o_last  (bus.word_last)
    );

    assign bus.byte_ready = w_byte_ready;
    assign bus.byte_idx   = r_byte_idx;
endmodule

// File: tb/tb_aes_byte_packer.sv
// Directed and throttled-stream checks of the byte packer at WORDS_PER_BLOCK 4 and 1.
module tb_aes_byte_packer;
    import aes_byte_packer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       word_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_part;
    logic [1:0]  m_idx;
    logic        m_valid;
    int          n_words;

    aes_byte_packer_if if4 ();
    aes_byte_packer_if if1 ();

    assign if4.byte_in    = byte_in;
    assign if4.byte_valid = byte_valid;
    assign if4.word_ready = word_ready;
    assign if1.byte_in    = byte_in;
    assign if1.byte_valid = byte_valid;
    assign if1.word_ready = word_ready;

    aes_byte_packer #(.WORDS_PER_BLOCK(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort),
        .bus   (if4.slave)
    );

    aes_byte_packer #(.WORDS_PER_BLOCK(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        word_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        #1;
        check_eq("push_bready", 32'(if4.byte_ready), 32'd1);
        tick();
    endtask

    task automatic show_word(input string tag);
        $display("[TB] %s word_out=%h last4=%0d last1=%0d", tag, if4.word_out,
                 if4.word_last, if1.word_last);
    endtask

    // One throttled cycle: inputs applied, model predicts this edge's handshakes.
    task automatic rnd_cycle(input logic bv, input logic [7:0] b, input logic wr);
        logic exp_ready;
        logic hs;
        logic load;
        logic [31:0] exp_w;
        byte_valid = bv;
        byte_in    = b;
        word_ready = wr;
        #1;
        exp_ready = !(m_idx == 2'd3 && m_valid && !wr);
        check_eq("rnd_bready", 32'(if4.byte_ready), 32'(exp_ready));
        check_eq("rnd_valid", 32'(if4.word_valid), 32'(m_valid));
        hs = m_valid && wr;
        if (hs) begin
            exp_w = exp_q.pop_front();
            check_eq("rnd_word", if4.word_out, exp_w);
            check_eq("rnd_last4", 32'(if4.word_last), 32'((n_words % 4) == 3));
            check_eq("rnd_last1", 32'(if1.word_last), 32'd1);
            show_word("rnd");
            n_words++;
        end
        load = bv && exp_ready && (m_idx == 2'd3);
        if (bv && exp_ready) begin
            m_part = {m_part[23:0], b};
            if (m_idx == 2'd3) exp_q.push_back(m_part);
            m_idx = m_idx + 2'd1;
        end
        m_valid = load ? 1'b1 : (hs ? 1'b0 : m_valid);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with a byte offered so byte_ready gating is visible.
        rst_n      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        word_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", 32'(if4.word_valid), 32'd0);
        check_eq("rst_out", if4.word_out, 32'h0);
        check_eq("rst_last", 32'(if4.word_last), 32'd0);
        check_eq("rst_idx", 32'(if4.byte_idx), 32'd0);
        check_eq("rst_bready", 32'(if4.byte_ready), 32'd0);
        rst_n = 1'b1;

        // Continuous stream
        push(8'h32); push(8'h43); push(8'hF6); push(8'hA8);
        check_eq("t1_valid", 32'(if4.word_valid), 32'd1);
        check_eq("t1_word", if4.word_out, 32'h3243F6A8);
        check_eq("t1_last4", 32'(if4.word_last), 32'd0);
        check_eq("t1_last1", 32'(if1.word_last), 32'd1);
        show_word("stream");
        byte_valid = 1'b0;
        tick();
        check_eq("t1_vdrop", 32'(if4.word_valid), 32'd0);

        // Block framing over two blocks
        do_reset();
        for (int i = 0; i < 32; i++) begin
            push(8'(i));
            check_eq("blk_idx", 32'(if4.byte_idx), 32'((i + 1) % 4));
            if (i % 4 == 3) begin
                check_eq("blk_valid", 32'(if4.word_valid), 32'd1);
                check_eq("blk_word", if4.word_out,
                         {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)});
                check_eq("blk_last4", 32'(if4.word_last), 32'((i / 4) % 4 == 3));
                check_eq("blk_last1", 32'(if1.word_last), 32'd1);
                show_word("block");
            end
        end
        byte_valid = 1'b0;
        tick();

        // Backpressure
        do_reset();
        push(8'hA0); push(8'hA1); push(8'hA2);
        word_ready = 1'b0;
        push(8'hA3);
        check_eq("bp_valid", 32'(if4.word_valid), 32'd1);
        check_eq("bp_word1", if4.word_out, 32'hA0A1A2A3);
        push(8'hB0); push(8'hB1); push(8'hB2);
        check_eq("bp_idx", 32'(if4.byte_idx), 32'd3);
        byte_in    = 8'hB3;
        byte_valid = 1'b1;
        #1;
        check_eq("bp_stall", 32'(if4.byte_ready), 32'd0);
        tick();
        check_eq("bp_hold", if4.word_out, 32'hA0A1A2A3);
        check_eq("bp_hold_v", 32'(if4.word_valid), 32'd1);
        check_eq("bp_hold_idx", 32'(if4.byte_idx), 32'd3);
        word_ready = 1'b1;
        #1;
        check_eq("bp_release", 32'(if4.byte_ready), 32'd1);
        tick();
        check_eq("bp_word2", if4.word_out, 32'hB0B1B2B3);
        check_eq("bp_valid2", 32'(if4.word_valid), 32'd1);
        show_word("backpressure");
        byte_valid = 1'b0;
        tick();
        check_eq("bp_vdrop", 32'(if4.word_valid), 32'd0);

        // Abort mid-word, with a stalled word already valid and word_idx at 3
        do_reset();
        for (int i = 0; i < 12; i++) push(8'(i));
        word_ready = 1'b0;
        push(8'hAA); push(8'hBB);
        byte_in    = 8'hCC;
        byte_valid = 1'b1;
        abort      = 1'b1;
        #1;
        check_eq("ab_bready", 32'(if4.byte_ready), 32'd0);
        tick();
        abort = 1'b0;
        check_eq("ab_idx", 32'(if4.byte_idx), 32'd0);
        check_eq("ab_keep_v", 32'(if4.word_valid), 32'd1);
        check_eq("ab_keep_w", if4.word_out, 32'h08090A0B);
        word_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check_eq("ab_word", if4.word_out, 32'h11223344);
        check_eq("ab_last4", 32'(if4.word_last), 32'd0);
        check_eq("ab_last1", 32'(if1.word_last), 32'd1);
        show_word("abort");
        byte_valid = 1'b0;
        tick();

        // Reset mid-block with word_idx at 3 and a partial word
        do_reset();
        for (int i = 0; i < 14; i++) push(8'(i));
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_eq("mr_bready", 32'(if4.byte_ready), 32'd0);
        tick();
        check_eq("mr_valid", 32'(if4.word_valid), 32'd0);
        check_eq("mr_out", if4.word_out, 32'h0);
        check_eq("mr_idx", 32'(if4.byte_idx), 32'd0);
        rst_n = 1'b1;
        push(8'h50); push(8'h51); push(8'h52); push(8'h53);
        check_eq("mr_word", if4.word_out, 32'h50515253);
        check_eq("mr_last4", 32'(if4.word_last), 32'd0);
        show_word("rst_mid");
        byte_valid = 1'b0;
        tick();

        // Throttled stream against the scoreboard
        do_reset();
        m_part  = '0;
        m_idx   = '0;
        m_valid = 1'b0;
        n_words = 0;
        for (int c = 0; c < 600; c++) begin
            rnd_cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int c = 0; c < 4; c++) rnd_cycle(1'b0, 8'h00, 1'b1);
        check_eq("rnd_drained", 32'(if4.word_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
